// File: rtl/pool_window_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : pool_window_feeder_if
// Brief    : Pixel-in / window-out handshake bundle for pool_window_feeder.
//            "master" is the side that supplies pixels and consumes windows;
//            "slave" is the feeder itself.
// Revision : 1.0 - initial release
// ============================================================================
interface pool_window_feeder_if #(
    parameter int DEPTH = 8,
    parameter int X     = 3,
    parameter int Y     = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DEPTH-1:0]       in_data;
    logic                   win_valid;
    logic                   win_ready;
    logic [DEPTH*X*Y-1:0]   win_data;
    logic                   win_last;

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data, win_last
    );

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data, win_last
    );
endinterface
`default_nettype wire

// File: rtl/pool_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pool_window_feeder
// Brief    : Turns a row-major pixel stream into non-overlapping X-by-Y
//            windows for the max pooler. Y-1 rows are buffered so each window
//            is emitted in a single beat, top-left pixel in the MSBs.
// Revision : 1.0 - initial release
// ============================================================================
module pool_window_feeder #(
    parameter int DEPTH = 8,
    parameter int X     = 3,
    parameter int Y     = 3,
    parameter int IMG_W = 9,
    parameter int IMG_H = 9
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    pool_window_feeder_if.slave  bus
);

    localparam int c_NB = IMG_H / Y;
    localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_RW = (Y > 1)     ? $clog2(Y)     : 1;
    localparam int c_BW = (c_NB > 1)  ? $clog2(c_NB)  : 1;

    localparam logic [c_CW-1:0] c_COL_MAX       = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_RIB_MAX       = c_RW'(Y - 1);
    localparam logic [c_RW-1:0] c_RIB_LAST_FILL = c_RW'((Y > 1) ? Y - 2 : 0);
    localparam logic [c_BW-1:0] c_BAND_MAX      = c_BW'(c_NB - 1);

    localparam logic [0:0] c_FILL = 1'b0;
    localparam logic [0:0] c_EMIT = 1'b1;
    localparam logic [0:0] c_STATE_RST = (Y == 1) ? c_EMIT : c_FILL;

    logic [c_CW-1:0]        r_col;
    logic [c_RW-1:0]        r_rib;
    logic [c_BW-1:0]        r_band;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_emit;
    logic                   w_fill_wr;

    logic                   r_win_valid;
    logic                   r_win_last;
    logic [DEPTH*X*Y-1:0]   r_win_data;
    logic [DEPTH*X*Y-1:0]   w_win;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_row_end;
    logic                   w_col_end_win;
    logic                   w_frame_end;
    logic                   w_win_load;

    // Only a window stuck downstream can stall the input.
    assign w_in_ready    = !r_win_valid || bus.win_ready;
    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_row_end     = (r_col == c_COL_MAX);
    assign w_col_end_win = ((32'(r_col) % X) == (X - 1));
    assign w_frame_end   = w_row_end && (r_rib == c_RIB_MAX) && (r_band == c_BAND_MAX);
    assign w_win_load    = w_accept && w_emit && w_col_end_win;

    assign bus.in_ready  = w_in_ready;
    assign bus.win_valid = r_win_valid;
    assign bus.win_last  = r_win_last;
    assign bus.win_data  = r_win_data;

    // Position counters: column, row within band, band; all wrap into the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_rib  <= '0;
            r_band <= '0;
        end else if (w_accept) begin
            if (w_row_end) begin
                r_col <= '0;
                if (r_rib == c_RIB_MAX) begin
                    r_rib  <= '0;
                    r_band <= (r_band == c_BAND_MAX) ? '0 : r_band + 1'b1;
                end else begin
                    r_rib <= r_rib + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // FILL/EMIT state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_STATE_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state changes only at row ends: into EMIT after the last buffered row,
    // back to FILL after the bottom row of the band (never leaves EMIT when Y == 1).
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept && w_row_end) begin
            if (r_state == c_FILL) begin
                if (r_rib == c_RIB_LAST_FILL) begin
                    w_state_nxt = c_EMIT;
                end
            end else if (Y > 1) begin
                w_state_nxt = c_FILL;
            end
        end
    end

    // State decode: FILL rows go to the line buffer, EMIT rows build windows.
    always_comb begin
        w_emit    = (r_state == c_EMIT);
        w_fill_wr = w_accept && (r_state == c_FILL);
    end

    generate
        if (Y > 1) begin : g_lbuf
            logic [DEPTH-1:0] r_mem [0:(Y-1)*IMG_W-1];
            logic [31:0]      w_wr_addr;
            logic [31:0]      w_base;

            assign w_wr_addr = 32'(r_rib) * IMG_W + 32'(r_col);
            // First column of the window containing r_col; stays in range for any col.
            assign w_base    = (32'(r_col) / X) * X;

            // Buffer rows 0..Y-2 of the band as they stream past.
            always_ff @(posedge clk) begin
                if (w_fill_wr) begin
                    r_mem[w_wr_addr] <= bus.in_data;
                end
            end

            for (genvar r = 0; r < Y - 1; r++) begin : g_row
                for (genvar c = 0; c < X; c++) begin : g_col
                    assign w_win[DEPTH*(X*Y-(r*X+c))-1 -: DEPTH] =
                        r_mem[r*IMG_W + w_base + c];
                end
            end
        end

        if (X > 1) begin : g_sr
            logic [DEPTH-1:0] r_sr [0:X-2];

            // Bottom-row shift register: the X-1 pixels preceding the completing one.
            always_ff @(posedge clk) begin
                if (w_accept && w_emit) begin
                    for (int j = 0; j < X - 2; j++) begin
                        r_sr[j] <= r_sr[j+1];
                    end
                    r_sr[X-2] <= bus.in_data;
                end
            end

            for (genvar c = 0; c < X - 1; c++) begin : g_bot
                assign w_win[DEPTH*(X*Y-((Y-1)*X+c))-1 -: DEPTH] = r_sr[c];
            end
        end
    endgenerate

    // The completing pixel is the bottom-right element.
    assign w_win[DEPTH-1:0] = bus.in_data;

    // Output window register: load on completion, otherwise drop once taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_win_data  <= '0;
        end else if (w_win_load) begin
            r_win_valid <= 1'b1;
            r_win_last  <= w_frame_end;
            r_win_data  <= w_win;
        end else if (bus.win_ready) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pool_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_window_feeder
// Brief    : Directed self-checking bench for pool_window_feeder (9x9 image,
//            3x3 windows) plus a 4x2 image with 2x1 windows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_window_feeder;

    logic clk;
    logic rst_n;

    int n_cmp  = 0;
    int n_err  = 0;
    int stalls = 0;

    logic [71:0] q_data[$];
    bit          q_last[$];
    logic [15:0] q2_data[$];
    bit          q2_last[$];

    pool_window_feeder_if #(.DEPTH(8), .X(3), .Y(3)) bus ();
    pool_window_feeder_if #(.DEPTH(8), .X(2), .Y(1)) bus2 ();

    pool_window_feeder #(.DEPTH(8), .X(3), .Y(3), .IMG_W(9), .IMG_H(9)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pool_window_feeder #(.DEPTH(8), .X(2), .Y(1), .IMG_W(4), .IMG_H(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every window handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.win_valid && bus.win_ready) begin
            q_data.push_back(bus.win_data);
            q_last.push_back(bus.win_last);
        end
        if (bus2.win_valid && bus2.win_ready) begin
            q2_data.push_back(bus2.win_data);
            q2_last.push_back(bus2.win_last);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference window w (0..8, row-major) of a 9x9 frame whose pixel (r,c) = off + r*9 + c.
    function automatic logic [71:0] exp_win(input int off, input int w);
        logic [71:0] d;
        int wr;
        int wc;
        d  = '0;
        wr = w / 3;
        wc = w % 3;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                d[8*(9-(r*3+c))-1 -: 8] = 8'(off + (wr*3 + r)*9 + wc*3 + c);
            end
        end
        return d;
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.win_ready = 1'b1;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        bus2.win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_data.delete();
        q_last.delete();
        q2_data.delete();
        q2_last.delete();
        stalls = 0;
    endtask

    // Present one pixel and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic push(input int v);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(v);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.in_ready;
            if (!done) stalls++;
            @(posedge clk);
            #1;
        end
        if (!done) check("push_timeout", 72'(v), 72'hFFFF);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int off, input int base);
        for (int w = 0; w < 9; w++) begin
            check("win_data", q_data[base + w], exp_win(off, w));
            check("win_last", 72'(q_last[base + w]), 72'(w == 8));
        end
    endtask

    initial begin
        // ---------------- reset values (checked while reset is held) ----------
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.win_ready = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        bus2.win_ready = 1'b0;
        #1;
        check("rst_win_valid", 72'(bus.win_valid), 72'(0));
        check("rst_win_last",  72'(bus.win_last),  72'(0));
        check("rst_win_data",  bus.win_data,       72'(0));
        check("rst_in_ready",  72'(bus.in_ready),  72'(1));
        do_reset();

        // ---------------- defaults, no backpressure --------------------------
        for (int v = 0; v < 20; v++) push(v);
        check("pre_first_valid", 72'(bus.win_valid), 72'(0));
        push(20);
        check("first_valid", 72'(bus.win_valid), 72'(1));
        check("first_data", bus.win_data,
              {8'd0, 8'd1, 8'd2, 8'd9, 8'd10, 8'd11, 8'd18, 8'd19, 8'd20});
        for (int v = 21; v < 81; v++) push(v);
        idle(3);
        check("s1_count",  72'(q_data.size()), 72'(9));
        check("s1_stalls", 72'(stalls), 72'(0));
        check("s1_last_data", q_data[8],
              {8'd60, 8'd61, 8'd62, 8'd69, 8'd70, 8'd71, 8'd78, 8'd79, 8'd80});
        check_frame(0, 0);

        // ---------------- backpressure ---------------------------------------
        do_reset();
        for (int v = 0; v < 21; v++) push(v);
        bus.win_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'd21;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 72'(bus.in_ready), 72'(0));
            check("bp_hold_data", bus.win_data,
                  {8'd0, 8'd1, 8'd2, 8'd9, 8'd10, 8'd11, 8'd18, 8'd19, 8'd20});
            @(posedge clk);
            #1;
        end
        bus.win_ready = 1'b1;
        for (int v = 21; v < 81; v++) push(v);
        idle(3);
        check("bp_count", 72'(q_data.size()), 72'(9));
        check("bp_second", q_data[1],
              {8'd3, 8'd4, 8'd5, 8'd12, 8'd13, 8'd14, 8'd21, 8'd22, 8'd23});
        check_frame(0, 0);

        // ---------------- back-to-back frames --------------------------------
        do_reset();
        for (int v = 0; v < 81; v++) push(v);
        for (int v = 0; v < 81; v++) push(100 + v);
        idle(3);
        check("b2b_count",  72'(q_data.size()), 72'(18));
        check("b2b_stalls", 72'(stalls), 72'(0));
        check("b2b_first2", q_data[9],
              {8'd100, 8'd101, 8'd102, 8'd109, 8'd110, 8'd111, 8'd118, 8'd119, 8'd120});
        check_frame(0, 0);
        check_frame(100, 9);

        // ---------------- mid-frame reset ------------------------------------
        do_reset();
        for (int v = 0; v < 47; v++) push(v);
        bus.win_ready = 1'b0;
        push(47);
        bus.in_valid = 1'b0;
        check("mr_valid_before", 72'(bus.win_valid), 72'(1));
        rst_n = 1'b0;
        #1;
        check("mr_valid_dropped", 72'(bus.win_valid), 72'(0));
        check("mr_data_cleared",  bus.win_data,       72'(0));
        check("mr_in_ready",      72'(bus.in_ready),  72'(1));
        do_reset();
        for (int v = 0; v < 81; v++) push(v);
        idle(3);
        check("mr_count", 72'(q_data.size()), 72'(9));
        check_frame(0, 0);

        // ---------------- bubbles on in_valid --------------------------------
        do_reset();
        for (int v = 0; v < 81; v++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            push(v);
        end
        idle(3);
        check("bub_count", 72'(q_data.size()), 72'(9));
        check_frame(0, 0);

        // ---------------- non-square: X=2, Y=1, 4x2 image --------------------
        do_reset();
        for (int v = 0; v < 8; v++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = 8'(v);
            @(negedge clk);
            check("ns_in_ready", 72'(bus2.in_ready), 72'(1));
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ns_count", 72'(q2_data.size()), 72'(4));
        for (int w = 0; w < 4; w++) begin
            check("ns_data", 72'(q2_data[w]), 72'({8'(2*w), 8'(2*w + 1)}));
            check("ns_last", 72'(q2_last[w]), 72'(w == 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
